// File: rtl/udp_rx_parser.sv
// UDP receive header parser: filters datagrams on destination port and forwards
// only payload bytes, with first/last markers, to a downstream byte ring buffer.
module udp_rx_parser #(
    parameter logic [15:0] LISTEN_PORT = 16'd5000,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_first,
    input  logic             in_last,
    output logic             wr_en,
    output logic [7:0]       wrdata,
    output logic             wr_first,
    output logic             wr_last,
    output logic [15:0]      src_port,
    output logic [15:0]      payload_len,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] drop_count
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, SKIP} state_t;

    state_t state, state_d;

    // Header bytes 0..6 shift through here; byte 7 is consumed straight from in_data.
    logic [55:0]      hdr_q, hdr_d;
    logic [3:0]       hdr_cnt, hdr_cnt_d;
    logic [15:0]      remaining, remaining_d;
    logic             first_pend, first_pend_d;
    logic             wr_en_d, wr_first_d, wr_last_d;
    logic [7:0]       wrdata_d;
    logic [15:0]      src_port_d, payload_len_d;
    logic             pkt_inc;
    logic [1:0]       drop_inc;
    logic [15:0]      dst_now, len_now;

    assign dst_now = {hdr_q[7:0], in_data};
    assign len_now = hdr_q[23:8];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d       = state;
        hdr_d         = hdr_q;
        hdr_cnt_d     = hdr_cnt;
        remaining_d   = remaining;
        first_pend_d  = first_pend;
        wr_en_d       = 1'b0;
        wrdata_d      = wrdata;
        wr_first_d    = 1'b0;
        wr_last_d     = 1'b0;
        src_port_d    = src_port;
        payload_len_d = payload_len;
        pkt_inc       = 1'b0;
        drop_inc      = 2'd0;

        if (in_valid) begin
            if (in_first) begin
                // A new datagram always restarts parsing; an open payload is abandoned unclosed.
                if (state == PAYLOAD)
                    drop_inc = drop_inc + 2'd1;
                hdr_d     = {hdr_q[47:0], in_data};
                hdr_cnt_d = 4'd1;
                if (in_last) begin
                    drop_inc = drop_inc + 2'd1;
                    state_d  = IDLE;
                end else begin
                    state_d  = HDR;
                end
            end else begin
                case (state)
                    HDR: begin
                        hdr_d     = {hdr_q[47:0], in_data};
                        hdr_cnt_d = hdr_cnt + 4'd1;
                        if (in_last) begin
                            drop_inc = 2'd1;
                            state_d  = IDLE;
                        end else if (hdr_cnt == 4'd3 && dst_now != LISTEN_PORT) begin
                            drop_inc = 2'd1;
                            state_d  = SKIP;
                        end else if (hdr_cnt == 4'd7) begin
                            if (len_now < 16'd9) begin
                                drop_inc = 2'd1;
                                state_d  = SKIP;
                            end else begin
                                remaining_d   = len_now - 16'd8;
                                src_port_d    = hdr_q[55:40];
                                payload_len_d = len_now - 16'd8;
                                first_pend_d  = 1'b1;
                                state_d       = PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        wr_en_d      = 1'b1;
                        wrdata_d     = in_data;
                        wr_first_d   = first_pend;
                        wr_last_d    = (remaining == 16'd1) || in_last;
                        first_pend_d = 1'b0;
                        remaining_d  = remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            pkt_inc = 1'b1;
                            state_d = in_last ? IDLE : SKIP;
                        end else if (in_last) begin
                            drop_inc = 2'd1;
                            state_d  = IDLE;
                        end
                    end
                    SKIP: begin
                        if (in_last)
                            state_d = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hdr_q       <= '0;
            hdr_cnt     <= '0;
            remaining   <= '0;
            first_pend  <= 1'b0;
            wr_en       <= 1'b0;
            wrdata      <= '0;
            wr_first    <= 1'b0;
            wr_last     <= 1'b0;
            src_port    <= '0;
            payload_len <= '0;
            pkt_count   <= '0;
            drop_count  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
            state       <= state_d;
            hdr_q       <= hdr_d;
            hdr_cnt     <= hdr_cnt_d;
            remaining   <= remaining_d;
            first_pend  <= first_pend_d;
            wr_en       <= wr_en_d;
            wrdata      <= wrdata_d;
            wr_first    <= wr_first_d;
            wr_last     <= wr_last_d;
            src_port    <= src_port_d;
            payload_len <= payload_len_d;
            pkt_count   <= pkt_count + CNT_W'(pkt_inc);
            drop_count  <= drop_count + CNT_W'(drop_inc);
        end
    end

endmodule

// File: tb/tb_udp_rx_parser.sv
// Self-checking bench for udp_rx_parser: directed scenarios plus randomized datagrams
// scored against a per-datagram outcome model.
module tb_udp_rx_parser;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_first, in_last;
    logic [7:0]  in_data;
    logic        wr_en, wr_first, wr_last;
    logic [7:0]  wrdata;
    logic [15:0] src_port, payload_len, pkt_count, drop_count;

    udp_rx_parser #(.LISTEN_PORT(16'd5000), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_first(in_first), .in_last(in_last), .wr_en(wr_en), .wrdata(wrdata),
        .wr_first(wr_first), .wr_last(wr_last), .src_port(src_port),
        .payload_len(payload_len), .pkt_count(pkt_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        bit         f;
        bit         l;
        int         idx;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  dg[$];
    int          byte_cyc[256];
    int          m_pkt, m_drop;
    logic [15:0] m_src, m_plen;

    // Expected outcome of a datagram of which k bytes are presented; ended says
    // whether byte k-1 carries in_last (otherwise the next in_first cuts it off).
    task automatic model(input int k, input bit ended);
        logic [15:0] len;
        int          l_pay, p_got;
        if (k >= 4 && {dg[2], dg[3]} != 16'd5000) begin
            m_drop++;
            return;
        end
        if (k < 8) begin
            if (ended) m_drop++;
            return;
        end
        len = {dg[4], dg[5]};
        if (len < 16'd9) begin
            m_drop++;
            return;
        end
        l_pay = int'(len) - 8;
        p_got = k - 8;
        if (!(k == 8 && ended)) begin
            m_src  = {dg[0], dg[1]};
            m_plen = 16'(l_pay);
        end
        if (p_got >= l_pay) begin
            for (int j = 0; j < l_pay; j++)
                exp_q.push_back('{dg[8+j], j == 0, j == l_pay - 1, 8 + j});
            m_pkt++;
        end else begin
            for (int j = 0; j < p_got; j++)
                exp_q.push_back('{dg[8+j], j == 0, ended && (j == p_got - 1), 8 + j});
            m_drop++;
        end
    endtask

    task automatic build(input logic [15:0] src, input logic [15:0] dst,
                         input logic [15:0] len, input int nbody);
        dg.delete();
        dg.push_back(src[15:8]); dg.push_back(src[7:0]);
        dg.push_back(dst[15:8]); dg.push_back(dst[7:0]);
        dg.push_back(len[15:8]); dg.push_back(len[7:0]);
        dg.push_back(8'($urandom)); dg.push_back(8'($urandom));
        for (int i = 0; i < nbody; i++) dg.push_back(8'($urandom));
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_data = 8'h00;
    endtask

    task automatic send(input int k, input bit ended, input int maxgap);
        for (int i = 0; i < k; i++) begin
            repeat ($urandom_range(0, maxgap)) idle_cycle();
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = dg[i];
            in_first = (i == 0);
            in_last  = ended && (i == k - 1);
            byte_cyc[i] = cyc;
        end
        idle_cycle();
    endtask

    task automatic run_dg(input int k, input bit ended, input int maxgap);
        model(k, ended);
        send(k, ended, maxgap);
    endtask

    task automatic check_status(input string tag);
        repeat (2) idle_cycle();
        check({tag, "_pkt_count"},   pkt_count,    m_pkt[15:0]);
        check({tag, "_drop_count"},  drop_count,   m_drop[15:0]);
        check({tag, "_src_port"},    src_port,     m_src);
        check({tag, "_payload_len"}, payload_len,  m_plen);
        check({tag, "_pending_wr"},  exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_data = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        m_pkt = 0; m_drop = 0; m_src = 16'h0; m_plen = 16'h0;
        exp_q.delete();
        check("rst_wr_en",       wr_en,       0);
        check("rst_wr_first",    wr_first,    0);
        check("rst_wr_last",     wr_last,     0);
        check("rst_wrdata",      wrdata,      0);
        check("rst_src_port",    src_port,    0);
        check("rst_payload_len", payload_len, 0);
        check("rst_pkt_count",   pkt_count,   0);
        check("rst_drop_count",  drop_count,  0);
    endtask

    wr_t mon_e;
    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr", wr_en, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_byte", {wrdata, wr_first, wr_last}, {mon_e.d, mon_e.f, mon_e.l});
                check("wr_latency", cyc, byte_cyc[mon_e.idx] + 1);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, nbody, lpay;
        bit ended;
        logic [15:0] dst, len;
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        do_reset();

        // Accepted datagram with payload A1..A4
        build(16'h1234, 16'd5000, 16'h000C, 4);
        for (int i = 0; i < 4; i++) dg[8+i] = 8'hA1 + 8'(i);
        run_dg(12, 1'b1, 0);
        check_status("accept");

        // Wrong destination port, then a normal datagram
        do_reset();
        build(16'h0001, 16'h1389, 16'h000C, 4);
        run_dg(12, 1'b1, 0);
        check_status("wrong_port");
        build(16'h0002, 16'd5000, 16'h000C, 4);
        run_dg(12, 1'b1, 1);
        check_status("after_wrong_port");

        // One payload byte followed by 17 pad bytes
        do_reset();
        build(16'hBEEF, 16'd5000, 16'h0009, 18);
        dg[8] = 8'h55;
        run_dg(26, 1'b1, 0);
        check_status("padding");

        // Truncated: 8 payload bytes announced, in_last on the 3rd
        do_reset();
        build(16'h0003, 16'd5000, 16'h0010, 3);
        run_dg(11, 1'b1, 0);
        check_status("truncation");

        // Abort on the 2nd payload byte, then a complete datagram
        do_reset();
        build(16'h0004, 16'd5000, 16'h000C, 4);
        run_dg(9, 1'b0, 0);
        build(16'h0005, 16'd5000, 16'h000E, 6);
        run_dg(14, 1'b1, 0);
        check_status("abort");
        build(16'h0006, 16'd5000, 16'h0008, 2);
        run_dg(10, 1'b1, 0);
        check_status("len8");

        // Reset after two payload bytes, then a gapped datagram
        build(16'h0007, 16'd5000, 16'h000C, 4);
        run_dg(10, 1'b0, 0);
        do_reset();
        build(16'h0008, 16'd5000, 16'h000D, 5);
        run_dg(13, 1'b1, 3);
        check_status("after_reset");

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            dst = ($urandom_range(0, 9) < 8) ? 16'd5000 : 16'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                len  = 16'($urandom_range(0, 8));
                lpay = 2;
            end else begin
                lpay = $urandom_range(1, 20);
                len  = 16'(lpay + 8);
            end
            nbody = $urandom_range(0, lpay + 6);
            build(16'($urandom), dst, len, nbody);
            ended = (n == 299) || ($urandom_range(0, 6) != 0);
            if (!ended)
                k = $urandom_range(1, 8 + nbody);
            else if ($urandom_range(0, 19) == 0)
                k = $urandom_range(1, 7);
            else
                k = 8 + nbody;
            run_dg(k, ended, 3);
            if (ended) begin
                check_status("rand");
                // Stray bytes without in_first between datagrams must be ignored
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    in_valid = 1'b1; in_data = 8'($urandom);
                    in_first = 1'b0; in_last = 1'($urandom);
                end
                idle_cycle();
            end
        end
        check_status("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/udp_rx_parser.md
# udp_rx_parser

Receive-side UDP header parser that sits directly upstream of the 64-entry byte ring buffer. It consumes a byte stream of UDP datagrams (UDP header onward, IP already stripped) and filters on destination port. For each accepted datagram it writes only the payload bytes into the buffer's write port, marking the first and last payload bytes. Header fields and per-datagram counters are exported for status.

## Interface
- LISTEN_PORT, 16'd5000, destination port accepted; all others are dropped.
- CNT_W, 16, width of the packet and drop counters.

Ports:
- clk  in  1  single clock; also drives the buffer's wr_clk.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_data carries a byte this cycle.
- in_data  in  8  UDP datagram byte; byte 0 is the source-port MSB.
- in_first  in  1  with in_valid: first byte of a datagram.
- in_last  in  1  with in_valid: last byte of a datagram.
- wr_en  out  1  write strobe to the buffer.
- wrdata  out  8  payload byte.
- wr_first  out  1  first payload byte of the datagram.
- wr_last  out  1  last payload byte of the datagram.
- src_port  out  16  source port of the last accepted datagram.
- payload_len  out  16  UDP length minus 8, for the last accepted datagram.
- pkt_count  out  CNT_W  accepted datagrams (wraps).
- drop_count  out  CNT_W  dropped, malformed or truncated datagrams (wraps).

## Operation
- FSM states: IDLE, HDR, PAYLOAD, SKIP.
- IDLE: on in_valid && in_first, latch byte 0, set hdr_cnt=1, go to HDR. Bytes without in_first are ignored.
- HDR: on each valid byte, latch it into the header register and increment hdr_cnt.
  - Bytes 0-1: src port. Bytes 2-3: dst port. Bytes 4-5: length. Bytes 6-7: checksum (stored, not verified).
  - After byte 3: if dst != LISTEN_PORT, increment drop_count and go to SKIP.
  - After byte 7: if length < 9, increment drop_count and go to SKIP. Otherwise set remaining = length-8, update src_port and payload_len, and go to PAYLOAD.
- PAYLOAD: each valid byte is written (wr_en=1, wrdata=in_data) and remaining is decremented.
  - wr_first=1 on the first payload byte.
  - wr_last=1 when remaining==1, or on in_last.
  - When remaining==1 with no in_last: increment pkt_count and go to SKIP to discard trailing pad.
  - When remaining==1 with in_last: increment pkt_count and go to IDLE.
  - in_last while remaining>1 (truncated datagram): write the byte with wr_last=1, increment drop_count (not pkt_count), go to IDLE.
- SKIP: discard bytes; go to IDLE on in_last.
- In_last during HDR (short header): increment drop_count, go to IDLE, no writes.
- 1-byte payload: wr_first=1 and wr_last=1 on the same write.
- in_first in any non-IDLE state aborts the current datagram and restarts header parsing with this byte as byte 0.
  - If aborted in PAYLOAD: increment drop_count; no closing wr_last is emitted.
- in_first and in_last together (1-byte datagram): counts as a drop; stay in IDLE.
- No backpressure: the buffer has no full flag. Upstream must keep average rate within drain rate; overflow is the buffer's concern.
- Width rules: length and remaining are 16-bit unsigned; length-8 is computed only when length ≥ 9. Counters wrap modulo 2^CNT_W.

## Timing
- Reset values: wr_en=0, wr_first=0, wr_last=0, wrdata=0, src_port=0, payload_len=0, pkt_count=0, drop_count=0; FSM=IDLE.
- All outputs are registered. wr_* appears exactly 1 cycle after the corresponding in_valid byte; wr_en is a single-cycle pulse per byte.
- in_valid may gap arbitrarily. The state holds with no writes during gaps.
- src_port and payload_len update on the cycle after byte 7 is accepted, before the first payload write appears.
- pkt_count and drop_count update 1 cycle after the deciding byte.
- rst asserted mid-datagram returns to IDLE next cycle and forces wr_en=0. The partial datagram is not closed and is not counted.

## Test plan
- Accepted datagram:
  - Stimulus: dst=5000 (0x1388), length=0x000C, payload 0xA1..0xA4, in_last on 0xA4.
  - Required: 4 writes, wr_first on 0xA1, wr_last on 0xA4; pkt_count=1, payload_len=4.
- Wrong port:
  - Stimulus: dst=0x1389, 12-byte datagram.
  - Required: no wr_en; drop_count=1; next valid datagram accepted normally.
- Ethernet padding:
  - Stimulus: length=0x0009 (1 payload byte 0x55) followed by 17 pad bytes, in_last on the final pad.
  - Required: one write with wr_first=wr_last=1, data 0x55; pad ignored; pkt_count=1.
- Truncation:
  - Stimulus: length=0x0010 but in_last on the 3rd payload byte.
  - Required: 3 writes, wr_last on the 3rd; drop_count=1, pkt_count=0.
- Abort and length check:
  - Stimulus: in_first arriving during the 2nd payload byte of datagram A, then a full valid datagram B.
  - Required: A's drop_count +1 and B written intact. Separately, length=0x0008 gives a drop with no writes.
- Reset mid-payload:
  - Stimulus: rst for 1 cycle after 2 payload bytes, then a valid datagram with in_valid gaps of 0-3 cycles.
  - Required: all outputs return to reset values; the new datagram is written with correct first/last and 1-cycle latency per byte.
